writeback_unit: RTL

- Producer side of the writeback interface; its output is the sole source of register-file and predicate (ps) writes.
- Merges two result sources into one registered writeback stream:
  - single-cycle ALU results;
  - variable-latency, in-order memory load returns.
- Tracks outstanding loads in a small queue and exports a pending-register mask for hazard detection by issue/decode.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/load_queue.sv | 67 ++++++
 rtl/writeback_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback path: register-file geometry,
// writeback source select and the registered writeback bundle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wb_pkg;

    localparam int DATA_W     = `DATA_WIDTH;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic                  use_rw;
        logic [REG_ADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]     data;
        logic                  write_ps;
        logic                  ps;
    } wb_bundle_t;

endpackage

// File: rtl/load_queue.sv
// In-order FIFO of outstanding load destinations. Exposes every slot's
// valid bit and address so the parent can build a pending-register mask.
module load_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [AW-1:0]             addr_i,
    output logic [AW-1:0]             head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [DEPTH-1:0]          ent_valid_o,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            wr_q, rd_q;
    logic [CW-1:0]            cnt_q;
    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic                     do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // No full-bypass: a pop in the same cycle does not make room for a push.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_o      = addr_q[rd_q];
    assign ent_valid_o = vld_q;
    assign ent_addr_o  = addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            if (do_push) begin
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + 1'b1;
            end
            // Push and pop never hit the same slot: that needs empty or full.
            if (do_pop) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) addr_q[wr_q] <= addr_i;
    end

endmodule

// File: rtl/writeback_unit.sv
// Merges single-cycle ALU results and in-order load returns into one
// registered writeback stream; tracks outstanding loads for hazard checks.
module writeback_unit #(
    parameter int DATA_WIDTH = wb_pkg::DATA_W,
    parameter int REG_ADDR_W = 4,
    parameter int LQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic                  alu_use_rw,
    input  logic [REG_ADDR_W-1:0] alu_rw_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  alu_write_ps,
    input  logic                  alu_ps,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [REG_ADDR_W-1:0] ld_rw_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  wb_valid,
    output logic                  wb_use_rw,
    output logic [REG_ADDR_W-1:0] wb_rw_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_write_ps,
    output logic                  wb_ps,
    output logic [15:0]           pending_mask,
    output logic                  rsp_underflow
);

    import wb_pkg::*;

    logic [REG_ADDR_W-1:0]               lq_head;
    logic                                lq_full, lq_empty;
    logic [LQ_DEPTH-1:0]                 lq_vld;
    logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0] lq_addr;

    wb_src_e    src;
    wb_bundle_t wb_d, wb_q;
    logic       underflow_q;

    load_queue #(
        .DEPTH (LQ_DEPTH),
        .AW    (REG_ADDR_W)
    ) u_lq (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (ld_issue_valid),
        .pop_i       (src == WB_MEM),
        .addr_i      (ld_rw_addr),
        .head_o      (lq_head),
        .full_o      (lq_full),
        .empty_o     (lq_empty),
        .ent_valid_o (lq_vld),
        .ent_addr_o  (lq_addr)
    );

    // Load returns cannot be back-pressured, so they win; a response with no
    // matching load is dropped and must not stall the ALU.
    always_comb begin
        src = WB_NONE;
        if (mem_rsp_valid && !lq_empty) src = WB_MEM;
        else if (alu_valid)             src = WB_ALU;
    end

    assign alu_ready      = !(mem_rsp_valid && !lq_empty);
    assign ld_issue_ready = !lq_full;

    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        case (src)
            WB_MEM: begin
                wb_d.valid    = 1'b1;
                wb_d.use_rw   = 1'b1;
                wb_d.rw_addr  = lq_head;
                wb_d.data     = mem_rsp_data;
                wb_d.write_ps = 1'b0;
                wb_d.ps       = 1'b0;
            end
            WB_ALU: begin
                wb_d.valid    = 1'b1;
                wb_d.use_rw   = alu_use_rw;
                wb_d.rw_addr  = alu_rw_addr;
                wb_d.data     = alu_data;
                wb_d.write_ps = alu_write_ps;
                wb_d.ps       = alu_ps;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= '0;
            underflow_q <= 1'b0;
        end else begin
            wb_q <= wb_d;
            if (mem_rsp_valid && lq_empty) underflow_q <= 1'b1;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_vld[i]) pending_mask[lq_addr[i]] = 1'b1;
        end
    end

    assign wb_valid      = wb_q.valid;
    assign wb_use_rw     = wb_q.use_rw;
    assign wb_rw_addr    = wb_q.rw_addr;
    assign wb_data       = wb_q.data;
    assign wb_write_ps   = wb_q.write_ps;
    assign wb_ps         = wb_q.ps;
    assign rsp_underflow = underflow_q;

endmodule
